demux4x32_buf: RTL and testbench
================================

Name: demux4x32_buf

Overview:
- 1-to-4 buffered demultiplexer for 32-bit words. It is the write-side counterpart to the 4-to-1 datapath select.
- Takes one valid/ready input stream tagged with a 2-bit destination select and steers each word into one of four independent 2-entry output buffers.
- Each buffer drains through its own valid/ready channel.
- Used in the monitor datapath to distribute one producer's words to four consumers (e.g. register/memory/display/debug sinks) without stalling unrelated channels.

Parameters:
- WIDTH, 32, data word width.
- CNTW, 16, width of the accepted-word counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clrn  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  word on in_data is accepted this cycle if in_valid=1.
- in_data  input  WIDTH  word to route.
- s  input  2  destination: 00 -> ch0, 01 -> ch1, 10 -> ch2, 11 -> ch3.
- y0, y1, y2, y3  output  WIDTH each  head word of channel 0..3.
- out_valid  output  4  bit i = channel i head word valid.
- out_ready  input  4  bit i = consumer i takes the head word.
- acc_cnt  output  CNTW  total words accepted since reset; wraps.

Behaviour:
- Reset (clrn=0, asynchronous): all buffers are emptied and all occupancy counts go to 0.
  - out_valid = 4'b0000; y0..y3 = 0; acc_cnt = 0.
  - in_ready reflects empty buffers, i.e. it is 1 once clrn=1.
  - Reset mid-transfer discards all buffered words. No partial state survives.
- Accept: a word is accepted when in_valid & in_ready at a rising edge.
  - in_ready = ~full[s]. It is combinational on s only, never on out_ready (no combinational path from out_ready).
  - The producer holds s and in_data stable while in_valid=1 and in_ready=0.
- Per-channel buffer: 2-entry FIFO, occupancy 0..2.
  - full = (count==2).
  - out_valid[i] = (count_i != 0).
  - y_i = head entry. y_i holds its last value when the channel is empty; at reset it is 0.
- Latency: a word pushed at edge N is visible on y_s with out_valid[s]=1 after edge N. There is no same-cycle bypass from in_data to y.
- Pop: occurs when out_valid[i] & out_ready[i] at an edge; the head advances. out_ready[i] while out_valid[i]=0 is ignored.
- Simultaneous push and pop on the same channel:
  - count=1: count stays 1; the new word becomes head.
  - count=2: no push is possible, since in_ready=0 for that s even if a pop occurs this cycle; the pop proceeds.
  - count=0: only the push is possible (pop is ignored).
- Pushes to channel k and pops on other channels in the same cycle are independent. All four channels may pop in one cycle.
- FIFO order is preserved per channel. There is no ordering guarantee across channels.
- acc_cnt increments by 1 on every accept and wraps from 2^CNTW-1 to 0.
- No state machine beyond the per-channel occupancy counters (0/1/2) and the 1-bit write/read pointers.

Decomposition:
- Shared package/header holds:
  - channel select constants CH0..CH3 = 2'd0..2'd3;
  - FIFO depth constant DEPTH = 2;
  - the shared WIDTH default.
- One sub-module, fifo2 (parameter WIDTH), is instantiated four times. Ports:
  - clk, clrn;
  - push, din, full;
  - pop, dout, nempty.
- The top level contains the select decode, the in_ready mux and acc_cnt only.

Test Plan:
- Reset: assert clrn=0 mid-stream with 2 words held in ch1 -> immediately out_valid=0000, y0..y3=0, acc_cnt=0. After release, in_ready=1 for all s.
- Routing: send 0x11111111 (s=0), 0x22222222 (s=1), 0x33333333 (s=2), 0x44444444 (s=3) with out_ready=0000 -> out_valid=1111, y0..y3 = those values, acc_cnt=4.
- Full/backpressure: out_ready=0, push 0xA0, 0xA1 to s=2 -> in_ready=0 when s=2 but 1 when s=0. Raise out_ready[2] -> y2 sequence 0xA0 then 0xA1, then out_valid[2]=0.
- Simultaneous push/pop at count=1: ch3 holds 0xB0, out_ready[3]=1, push 0xB1 to s=3 in the same cycle -> next cycle count stays 1, y3=0xB1, out_valid[3]=1.
- Streaming throughput: out_ready=1111, in_valid=1 continuously with s cycling 0..3 for 100 words -> in_ready stays 1, every word appears on the correct channel one cycle later, acc_cnt=100.
- Wrap: preload acc_cnt near its limit by sending 65535 words to a continuously drained channel, then one more word -> acc_cnt reads 0xFFFF, then 0x0000.

Source files
------------

// File: rtl/demux4x32_buf_pkg.sv
// Shared constants for the buffered 1-to-4 word demultiplexer.
package demux4x32_buf_pkg;
    localparam logic [1:0] CH0 = 2'd0;
    localparam logic [1:0] CH1 = 2'd1;
    localparam logic [1:0] CH2 = 2'd2;
    localparam logic [1:0] CH3 = 2'd3;

    localparam int NUM_CH    = 4;
    localparam int DEPTH     = 2;
    localparam int DEF_WIDTH = 32;
endpackage

// File: rtl/demux4x32_buf_fifo2.sv
// Two-entry FIFO; the head word is held on dout after the FIFO drains.
module fifo2
    import demux4x32_buf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             nempty
);
    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic                        wptr, rptr;
    logic [1:0]                  count;
    logic [WIDTH-1:0]            last;
    logic                        do_push, do_pop;

    assign full    = (count == 2'(DEPTH));
    assign nempty  = (count != 2'd0);
    assign do_push = push & ~full;
    assign do_pop  = pop & nempty;

    // last tracks the current head so an empty channel keeps showing it
    assign dout = nempty ? mem[rptr] : last;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mem   <= '0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
            last  <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= ~wptr;
            end
            if (do_pop)
                rptr <= ~rptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (nempty)
                last <= mem[rptr];
        end
    end
endmodule

// File: rtl/demux4x32_buf.sv
// Steers one valid/ready word stream into four independently drained 2-entry buffers.
module demux4x32_buf
    import demux4x32_buf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [CNTW-1:0]  acc_cnt
);
    logic [NUM_CH-1:0]            full;
    logic [NUM_CH-1:0]            push;
    logic [NUM_CH-1:0][WIDTH-1:0] dout;
    logic                         accept;

    // in_ready depends on the selected channel's fill state only, never on out_ready
    assign in_ready = ~full[s];
    assign accept   = in_valid & in_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign push[i] = accept & (s == 2'(i));

        fifo2 #(.WIDTH(WIDTH)) u_fifo (
            .clk    (clk),
            .clrn   (clrn),
            .push   (push[i]),
            .din    (in_data),
            .full   (full[i]),
            .pop    (out_ready[i]),
            .dout   (dout[i]),
            .nempty (out_valid[i])
        );
    end

    assign y0 = dout[CH0];
    assign y1 = dout[CH1];
    assign y2 = dout[CH2];
    assign y3 = dout[CH3];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            acc_cnt <= '0;
        else if (accept)
            acc_cnt <= acc_cnt + 1'b1;
    end
endmodule

// File: tb/tb_demux4x32_buf.sv
// Directed-vector bench for the buffered 1-to-4 demultiplexer.
module tb_demux4x32_buf;
    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [1:0]  s = 2'd0;
    logic [31:0] y0, y1, y2, y3;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = 4'b0000;
    logic [15:0] acc_cnt;

    int vectors = 0;
    int miscompares = 0;

    demux4x32_buf #(.WIDTH(32), .CNTW(16)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .s         (s),
        .y0        (y0),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_cnt   (acc_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ysel(input logic [1:0] ch);
        case (ch)
            2'd0:    return y0;
            2'd1:    return y1;
            2'd2:    return y2;
            default: return y3;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        clrn      = 1'b0;
        tick();
        clrn = 1'b1;
        tick();
    endtask

    task automatic push(input logic [1:0] ch, input logic [31:0] d);
        in_valid = 1'b1;
        s        = ch;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 4'b0000 || acc_cnt !== 16'd0 || y0 !== 0 || y1 !== 0 || y2 !== 0 || y3 !== 0) begin
            miscompares++;
            $display("FAIL reset_init: out_valid=%b acc=%h y=%h %h %h %h, want 0000/0/0", out_valid, acc_cnt, y0, y1, y2, y3);
        end
        tick();
        clrn = 1'b1;
        tick();
        push(2'd1, 32'hC0DE0001);
        push(2'd1, 32'hC0DE0002);
        vectors++;
        if (out_valid !== 4'b0010 || y1 !== 32'hC0DE0001 || acc_cnt !== 16'd2) begin
            miscompares++;
            $display("FAIL reset_preload: out_valid=%b y1=%h acc=%h, want 0010/c0de0001/2", out_valid, y1, acc_cnt);
        end
        // async assertion away from any clock edge
        #2 clrn = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 4'b0000 || acc_cnt !== 16'd0 || y0 !== 0 || y1 !== 0 || y2 !== 0 || y3 !== 0) begin
            miscompares++;
            $display("FAIL reset_async: out_valid=%b acc=%h y=%h %h %h %h, want 0000/0/0", out_valid, acc_cnt, y0, y1, y2, y3);
        end
        tick();
        clrn = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            s = 2'(k);
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_in_ready s=%0d: got %b want 1", k, in_ready);
            end
        end
    endtask

    task automatic test_routing();
        logic [31:0] exp [4];
        exp[0] = 32'h11111111; exp[1] = 32'h22222222;
        exp[2] = 32'h33333333; exp[3] = 32'h44444444;
        do_reset();
        for (int k = 0; k < 4; k++) push(2'(k), exp[k]);
        vectors++;
        if (out_valid !== 4'b1111 || acc_cnt !== 16'd4) begin
            miscompares++;
            $display("FAIL routing_valid: out_valid=%b acc=%0d, want 1111/4", out_valid, acc_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (ysel(2'(k)) !== exp[k]) begin
                miscompares++;
                $display("FAIL routing_y%0d: got %h want %h", k, ysel(2'(k)), exp[k]);
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        push(2'd2, 32'hA0);
        push(2'd2, 32'hA1);
        s = 2'd2;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_ready_s2: got %b want 0", in_ready);
        end
        s = 2'd0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL full_ready_s0: got %b want 1", in_ready);
        end
        out_ready = 4'b0100;
        #1;
        vectors++;
        if (y2 !== 32'hA0 || out_valid[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL full_head0: y2=%h v=%b want a0/1", y2, out_valid[2]);
        end
        tick();
        vectors++;
        if (y2 !== 32'hA1 || out_valid[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL full_head1: y2=%h v=%b want a1/1", y2, out_valid[2]);
        end
        tick();
        vectors++;
        if (out_valid[2] !== 1'b0 || y2 !== 32'hA1) begin
            miscompares++;
            $display("FAIL full_drained: v=%b y2=%h want 0/a1 held", out_valid[2], y2);
        end
        out_ready = 4'b0000;
    endtask

    task automatic test_push_pop();
        do_reset();
        push(2'd3, 32'hB0);
        out_ready = 4'b1000;
        in_valid  = 1'b1;
        s         = 2'd3;
        in_data   = 32'hB1;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || y3 !== 32'hB0) begin
            miscompares++;
            $display("FAIL pushpop_pre: ready=%b y3=%h want 1/b0", in_ready, y3);
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        #1;
        vectors++;
        if (out_valid[3] !== 1'b1 || y3 !== 32'hB1 || acc_cnt !== 16'd2) begin
            miscompares++;
            $display("FAIL pushpop_post: v=%b y3=%h acc=%0d want 1/b1/2", out_valid[3], y3, acc_cnt);
        end
        // one pop must empty it if the count stayed at 1
        out_ready = 4'b1000;
        tick();
        out_ready = 4'b0000;
        vectors++;
        if (out_valid[3] !== 1'b0) begin
            miscompares++;
            $display("FAIL pushpop_count: v=%b want 0", out_valid[3]);
        end
    endtask

    task automatic test_streaming();
        int bad = 0;
        do_reset();
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        for (int k = 0; k < 100; k++) begin
            s       = 2'(k % 4);
            in_data = 32'h5000_0000 + 32'(k);
            #1;
            if (in_ready !== 1'b1) bad++;
            tick();
            if (out_valid !== (4'b0001 << (k % 4)) || ysel(2'(k % 4)) !== 32'h5000_0000 + 32'(k)) bad++;
        end
        in_valid = 1'b0;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL stream_words: %0d bad cycles, want 0", bad);
        end
        vectors++;
        if (acc_cnt !== 16'd100) begin
            miscompares++;
            $display("FAIL stream_acc: got %0d want 100", acc_cnt);
        end
        out_ready = 4'b0000;
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 4'b0001;
        s         = 2'd0;
        in_data   = 32'hFACE;
        in_valid  = 1'b1;
        repeat (65535) tick();
        vectors++;
        if (acc_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL wrap_max: got %h want ffff", acc_cnt);
        end
        tick();
        in_valid = 1'b0;
        vectors++;
        if (acc_cnt !== 16'h0000) begin
            miscompares++;
            $display("FAIL wrap_zero: got %h want 0000", acc_cnt);
        end
        out_ready = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_routing();
        test_full();
        test_push_pop();
        test_streaming();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
